// File: rtl/mrd_source_if.sv
// mrd_source_if
// Stream bundle between the mixed-radix DFT core and the receive endpoint.
// Input side: valid/ready handshake, sop/eop framing, signed real/imag
// samples, a block exponent and the DFT size. Output side: valid/ready
// handshake, sop/eop framing, denormalized real/imag and the DFT size.
// Modports:
//   master - stream producer / consumer side (DFT core, testbench)
//   slave  - mrd_source_rx side
interface mrd_source_if #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic signed [IN_W-1:0]  in_real;
    logic signed [IN_W-1:0]  in_imag;
    logic [3:0]              in_exp;
    logic [11:0]             in_dftpts;

    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sop;
    logic                    out_eop;
    logic signed [OUT_W-1:0] out_real;
    logic signed [OUT_W-1:0] out_imag;
    logic [11:0]             out_dftpts;

    modport master (
        output in_valid, in_sop, in_eop, in_real, in_imag, in_exp, in_dftpts,
        input  in_ready,
        input  out_valid, out_sop, out_eop, out_real, out_imag, out_dftpts,
        output out_ready
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_real, in_imag, in_exp, in_dftpts,
        output in_ready,
        output out_valid, out_sop, out_eop, out_real, out_imag, out_dftpts,
        input  out_ready
    );
endinterface

// File: rtl/mrd_source_rx.sv
// mrd_source_rx
// Receive-side endpoint of the mixed-radix DFT output stream. Checks frame
// integrity against the DFT size latched on sop, denormalizes each sample by
// the block exponent (sample << exp) and re-emits it through a 2-entry
// output buffer with backpressure.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   s           - mrd_source_if.slave (input stream in_*, output stream out_*)
//   err_pulse   - one-cycle pulse per framing error
//   frame_cnt   - frames emitted with out_eop (wraps)
// Configuration macro:
//   MRD_RX_SAT_EN - when defined, denormalized samples saturate to the
//                   OUT_W signed range; otherwise the low OUT_W bits are kept.
//
// state | meaning
// IDLE  | waiting for a sop beat
// RUN   | inside a frame, counting beats against the latched DFT size
// DROP  | discarding beats until an eop beat is accepted
module mrd_source_rx #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    mrd_source_if.slave s,
    output logic        err_pulse,
    output logic [15:0] frame_cnt
);

    localparam int EW = OUT_W + 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [11:0]      dft;
        logic [OUT_W-1:0] re;
        logic [OUT_W-1:0] im;
    } ent_t;

    state_t      state, nstate;
    logic [11:0] cnt, cnt_d, cnt_n;
    logic [3:0]  exp_q, exp_use;
    logic [11:0] dft_q;
    logic        acc, push, pop, p_sop, p_eop, err_set, latch;
    logic [1:0]  occ;
    logic        rdy_en;
    ent_t        e0, e1, new_ent;

    function automatic logic [OUT_W-1:0] denorm(input logic signed [IN_W-1:0] x,
                                                input logic [3:0] e);
`ifdef MRD_RX_SAT_EN
        logic signed [EW-1:0] w;
        w = EW'(x);
        w = w <<< e;
        if (w[EW-1:OUT_W-1] == {(EW-OUT_W+1){w[EW-1]}})
            return w[OUT_W-1:0];
        else if (w[EW-1])
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b0, {(OUT_W-1){1'b1}}};
`else
        // The low OUT_W bits of the wide shift depend only on the low OUT_W
        // bits of the sign-extended input, so shift at OUT_W directly.
        logic signed [OUT_W-1:0] w;
        w = OUT_W'(x);
        w = w <<< e;
        return w;
`endif
    endfunction

    assign acc        = s.in_valid && s.in_ready;
    assign s.in_ready = rdy_en && (occ != 2'd2);
    assign s.out_valid = (occ != 2'd0);
    assign pop        = s.out_valid && s.out_ready;
    assign cnt_n      = cnt + 12'd1;
    // On the sop beat the exponent has not been latched yet.
    assign exp_use    = (state == S_IDLE) ? s.in_exp : exp_q;

    assign s.out_sop    = e0.sop;
    assign s.out_eop    = e0.eop;
    assign s.out_dftpts = e0.dft;
    assign s.out_real   = e0.re;
    assign s.out_imag   = e0.im;

    always_comb begin
        new_ent.sop = p_sop;
        new_ent.eop = p_eop;
        new_ent.dft = (state == S_IDLE) ? s.in_dftpts : dft_q;
        new_ent.re  = denorm(s.in_real, exp_use);
        new_ent.im  = denorm(s.in_imag, exp_use);
    end

    always_comb begin
        nstate  = state;
        cnt_d   = cnt;
        push    = 1'b0;
        p_sop   = 1'b0;
        p_eop   = 1'b0;
        err_set = 1'b0;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (s.in_sop) begin
                        latch = 1'b1;
                        cnt_d = 12'd1;
                        if (s.in_dftpts == 12'd0) begin
                            err_set = 1'b1;
                            nstate  = S_DROP;
                        end else begin
                            push  = 1'b1;
                            p_sop = 1'b1;
                            if (s.in_dftpts == 12'd1) begin
                                p_eop = 1'b1;
                                if (!s.in_eop) begin
                                    err_set = 1'b1;
                                    nstate  = S_DROP;
                                end
                            end else if (s.in_eop) begin
                                p_eop   = 1'b1;
                                err_set = 1'b1;
                            end else begin
                                nstate = S_RUN;
                            end
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (acc) begin
                    if (s.in_sop) begin
                        err_set = 1'b1;
                        nstate  = S_DROP;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_n;
                        if (cnt_n == dft_q) begin
                            p_eop = 1'b1;
                            if (s.in_eop) begin
                                nstate = S_IDLE;
                            end else begin
                                err_set = 1'b1;
                                nstate  = S_DROP;
                            end
                        end else if (s.in_eop) begin
                            p_eop   = 1'b1;
                            err_set = 1'b1;
                            nstate  = S_IDLE;
                        end
                    end
                end
            end
            S_DROP: begin
                if (acc && s.in_eop)
                    nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 12'd0;
            exp_q     <= 4'd0;
            dft_q     <= 12'd0;
            err_pulse <= 1'b0;
        end else begin
            state     <= nstate;
            cnt       <= cnt_d;
            err_pulse <= err_set;
            if (latch) begin
                exp_q <= s.in_exp;
                dft_q <= s.in_dftpts;
            end
        end
    end

    // e0 is the head entry and drives the outputs directly. A push while
    // occupancy is 2 cannot happen because in_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            e0        <= '0;
            e1        <= '0;
            rdy_en    <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            rdy_en <= 1'b1;
            if (pop && e0.eop)
                frame_cnt <= frame_cnt + 16'd1;
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= new_ent;
                    else             e1 <= new_ent;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) e0 <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    e0 <= new_ent;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mrd_source_rx.sv
module tb_mrd_source_rx;
    localparam int IN_W  = 18;
    localparam int OUT_W = 24;

    typedef struct {
        bit          sop;
        bit          eop;
        int          re;
        int          im;
        bit [3:0]    ex;
        bit [11:0]   dft;
    } beat_t;

    typedef struct {
        bit          sop;
        bit          eop;
        logic [23:0] re;
        logic [23:0] im;
        bit [11:0]   dft;
    } obeat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_pulse;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    mrd_source_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    mrd_source_rx #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (bus),
        .err_pulse (err_pulse),
        .frame_cnt (frame_cnt)
    );

    int     n_chk = 0;
    int     n_pass = 0;
    beat_t  stim[$];
    obeat_t expq[$];
    obeat_t cap[$];
    int     errs;
    int     lat_acc;
    int     lat_out;
    bit     saw_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic add_beat(input bit sop, input bit eop, input int re, input int im,
                            input bit [3:0] ex, input bit [11:0] dft);
        beat_t b;
        b.sop = sop; b.eop = eop; b.re = re; b.im = im; b.ex = ex; b.dft = dft;
        stim.push_back(b);
    endtask

    task automatic add_exp(input bit sop, input bit eop, input int re, input int im,
                           input bit [11:0] dft);
        obeat_t o;
        o.sop = sop; o.eop = eop; o.re = 24'(re); o.im = 24'(im); o.dft = dft;
        expq.push_back(o);
    endtask

    task automatic drive_beat(input beat_t b);
        bus.in_valid  = 1'b1;
        bus.in_sop    = b.sop;
        bus.in_eop    = b.eop;
        bus.in_real   = IN_W'(b.re);
        bus.in_imag   = IN_W'(b.im);
        bus.in_exp    = b.ex;
        bus.in_dftpts = b.dft;
    endtask

    // Streams stim[] into the DUT and collects popped output beats, then
    // compares them with expq[]. toggle=1 alternates out_ready every cycle.
    task automatic run(input bit toggle);
        int          idx;
        int          idle;
        bit          done;
        bit          prev_stall;
        logic [63:0] prev_bus;
        logic [63:0] cur_bus;
        obeat_t      o;
        idx = 0; idle = 0; done = 0; prev_stall = 0; prev_bus = '0;
        cap.delete();
        errs = 0; lat_acc = -1; lat_out = -1; saw_stall = 0;
        for (int t = 0; t < 600 && !done; t++) begin
            @(negedge clk);
            bus.out_ready = toggle ? t[0] : 1'b1;
            if (idx < stim.size()) drive_beat(stim[idx]);
            else bus.in_valid = 1'b0;
            #1;
            cur_bus = {2'b00, bus.out_sop, bus.out_eop, bus.out_dftpts,
                       bus.out_real, bus.out_imag};
            if (prev_stall) chk("hold", cur_bus, prev_bus);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_bus   = cur_bus;
            if (bus.in_valid && !bus.in_ready) saw_stall = 1;
            if (bus.in_valid && bus.in_ready) begin
                if (lat_acc < 0) lat_acc = t;
                idx++;
            end
            if (bus.out_valid && lat_out < 0) lat_out = t;
            if (bus.out_valid && bus.out_ready) begin
                o.sop = bus.out_sop; o.eop = bus.out_eop;
                o.re = bus.out_real; o.im = bus.out_imag; o.dft = bus.out_dftpts;
                cap.push_back(o);
            end
            if (err_pulse) errs++;
            if (idx == stim.size() && !bus.out_valid) idle++;
            else idle = 0;
            if (idle >= 4) done = 1;
        end
        bus.in_valid = 1'b0;
        if (!done) chk("timeout", 64'd0, 64'd1);
        chk("n_beats", 64'(cap.size()), 64'(expq.size()));
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            chk($sformatf("re[%0d]", i), 64'(cap[i].re), 64'(expq[i].re));
            chk($sformatf("im[%0d]", i), 64'(cap[i].im), 64'(expq[i].im));
            chk($sformatf("flags[%0d]", i), {50'd0, cap[i].sop, cap[i].eop, cap[i].dft},
                {50'd0, expq[i].sop, expq[i].eop, expq[i].dft});
        end
        stim.delete();
        expq.delete();
    endtask

    task automatic build_12pt();
        for (int i = 1; i <= 12; i++) begin
            // in_exp on non-sop beats carries junk that must be ignored
            add_beat(i == 1, i == 12, i, -1, (i == 1) ? 4'd3 : 4'd7, 12'd12);
            add_exp(i == 1, i == 12, 8 * i, -8, 12'd12);
        end
    endtask

    initial begin
        beat_t b;
        bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
        bus.in_real = '0; bus.in_imag = '0; bus.in_exp = '0; bus.in_dftpts = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outs", {26'd0, bus.out_sop, bus.out_eop, bus.out_dftpts, bus.out_real},
            64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err_pulse), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // 12-pt frame, exp 3, full throughput
        build_12pt();
        run(1'b0);
        chk("latency", 64'(lat_out - lat_acc), 64'd1);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_errs", 64'(errs), 64'd0);

        // same frame with out_ready toggling
        build_12pt();
        run(1'b1);
        chk("t2_in_ready_low", 64'(saw_stall), 64'd1);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("t2_errs", 64'(errs), 64'd0);

        // one-beat frames at the extremes of the shift
        add_beat(1, 1, 'h1FFFF, 0, 4'd15, 12'd1);
        add_beat(1, 1, 'h20000, 0, 4'd15, 12'd1);
        add_beat(1, 1, -1, 3, 4'd15, 12'd1);
`ifdef MRD_RX_SAT_EN
        add_exp(1, 1, 'h7FFFFF, 0, 12'd1);
        add_exp(1, 1, 'h800000, 0, 12'd1);
`else
        add_exp(1, 1, 'hFF8000, 0, 12'd1);
        add_exp(1, 1, 'h000000, 0, 12'd1);
`endif
        add_exp(1, 1, 'hFF8000, 'h018000, 12'd1);
        run(1'b0);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd5);
        chk("t3_errs", 64'(errs), 64'd0);

        // early eop on beat 10 of a 24-pt frame, then a normal 4-pt frame
        for (int i = 1; i <= 10; i++) begin
            add_beat(i == 1, i == 10, i, -i, 4'd0, 12'd24);
            add_exp(i == 1, i == 10, i, -i, 12'd24);
        end
        for (int i = 1; i <= 4; i++) begin
            add_beat(i == 1, i == 4, 100 + i, 0, 4'd1, 12'd4);
            add_exp(i == 1, i == 4, 2 * (100 + i), 0, 12'd4);
        end
        run(1'b0);
        chk("t4_frame_cnt", 64'(frame_cnt), 64'd7);
        chk("t4_errs", 64'(errs), 64'd1);

        // missing eop: 12-pt frame runs 15 beats, then a 2-pt frame
        for (int i = 1; i <= 15; i++) begin
            add_beat(i == 1, i == 15, i, 0, 4'd0, 12'd12);
            if (i <= 12) add_exp(i == 1, i == 12, i, 0, 12'd12);
        end
        add_beat(1, 0, 5, 1, 4'd2, 12'd2);
        add_beat(0, 1, 6, 1, 4'd2, 12'd2);
        add_exp(1, 0, 20, 4, 12'd2);
        add_exp(0, 1, 24, 4, 12'd2);
        run(1'b0);
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd9);
        chk("t5_errs", 64'(errs), 64'd1);

        // sop at beat 5 of a 12-pt frame, drop to eop, then a 3-pt frame
        for (int i = 1; i <= 8; i++) begin
            add_beat(i == 1 || i == 5, i == 8, i, 0, 4'd0, 12'd12);
            if (i <= 4) add_exp(i == 1, 0, i, 0, 12'd12);
        end
        for (int i = 1; i <= 3; i++) begin
            add_beat(i == 1, i == 3, 50 + i, -2, 4'd0, 12'd3);
            add_exp(i == 1, i == 3, 50 + i, -2, 12'd3);
        end
        run(1'b0);
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd10);
        chk("t6_errs", 64'(errs), 64'd1);

        // reset in the middle of a stalled frame
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            b.sop = (i == 1); b.eop = 0; b.re = 9; b.im = 9; b.ex = 4'd1; b.dft = 12'd12;
            drive_beat(b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("t7_pre_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t7_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t7_rst_outs", {26'd0, bus.out_sop, bus.out_eop, bus.out_dftpts, bus.out_real},
            64'd0);
        chk("t7_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t7_rst_err", 64'(err_pulse), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        // stray non-sop beat after reset is dropped with an error
        add_beat(0, 0, 1, 1, 4'd0, 12'd2);
        add_beat(1, 0, 7, 0, 4'd0, 12'd2);
        add_beat(0, 1, 8, 0, 4'd0, 12'd2);
        add_exp(1, 0, 7, 0, 12'd2);
        add_exp(0, 1, 8, 0, 12'd2);
        run(1'b0);
        chk("t7_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t7_errs", 64'(errs), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mrd_source_rx.md
# mrd_source_rx

Receive-side endpoint of the mixed-radix DFT output stream. It accepts the DFT core's source stream: valid/ready handshake, sop/eop framing, 18-bit real/imag samples, a 4-bit block exponent and the DFT size. It checks frame integrity against the frame's DFT size and denormalizes each sample by the block exponent. It then re-emits full-scale samples through a 2-entry output buffer with backpressure to downstream consumers such as the SC-FDMA demapper or host capture.

## Interface
- IN_W, 18, input sample width per component (signed)
- OUT_W, 24, output sample width per component (signed); must satisfy OUT_W >= IN_W
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_sop  input  1  first sample of a frame
- in_eop  input  1  last sample of a frame
- in_real, in_imag  input  IN_W  signed sample
- in_exp  input  4  block exponent, sampled on the sop beat only
- in_dftpts  input  12  DFT size, sampled on the sop beat only
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_sop, out_eop  output  1  output framing
- out_real, out_imag  output  OUT_W  denormalized sample
- out_dftpts  output  12  DFT size of the current output frame
- err_pulse  output  1  one-cycle pulse per framing error
- frame_cnt  output  16  count of frames emitted with out_eop; wraps at 0xFFFF

## Operation
- Accept rule: a beat is accepted when in_valid && in_ready.
- Ready rule: in_ready = (buffer occupancy < 2). The buffer pops on out_valid && out_ready. A push and a pop in the same cycle keeps occupancy unchanged, so the block sustains full throughput.
- Frame FSM states and transitions:
  - IDLE: an accepted beat with in_sop latches exp, dftpts and sets cnt=1. If dftpts is 0, raise err, drop the beat and go to DROP. Otherwise push the beat with out_sop=1 and go to RUN. A non-sop beat is dropped and raises err.
  - RUN: each accepted beat increments cnt and is pushed.
    - Normal end: the beat with cnt==dftpts is pushed with out_eop=1. If in_eop is also 1, go to IDLE. If in_eop is 0, raise err and go to DROP.
    - Early eop: in_eop with cnt<dftpts is pushed with out_eop=1, raises err, and the FSM goes to IDLE.
    - sop in RUN: raises err, the beat is dropped, and the FSM goes to DROP. The truncated frame gets no out_eop.
  - DROP: discard accepted beats until a beat with in_eop is accepted, then go to IDLE. A sop beat inside DROP is also discarded.
- A one-beat frame (dftpts==1) with sop and eop together is pushed with out_sop=out_eop=1 and the FSM stays in IDLE.
- Denormalization: out = sign_extend(in) << exp_latched, computed at OUT_W+15 bits, then reduced to OUT_W as set under Configuration. in_exp on non-sop beats is ignored.
- err_pulse fires at most once per cycle.
- frame_cnt increments when an out_eop beat is popped.

## Timing
- Reset values: in_ready=0 while rst_n is low, then 1 on the first clock after release. out_valid=0, out_sop=0, out_eop=0, out_real=out_imag=0, out_dftpts=0, err_pulse=0, frame_cnt=0. FSM goes to IDLE, cnt=0 and the buffer empties.
- Latency: a beat accepted in cycle N is presented with out_valid=1 in cycle N+1 when the buffer was empty.
- Output hold: while out_valid=1 and out_ready=0, all out_* signals are held stable.
- err_pulse asserts the cycle after the offending beat is accepted.
- Reset mid-frame: all state is discarded immediately. The next frame must start with sop. Beats still buffered are lost, with no eop and no error.
- Denormalization is fully combinational before the buffer write, so no extra latency.

## Configuration
- MRD_RX_SAT_EN defined: the shifted result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] per component.
- MRD_RX_SAT_EN undefined: the low OUT_W bits are kept (two's-complement wrap). This saves the comparator logic.

## Test plan
- 12-pt frame, exp=3, samples real=1..12, imag=-1, out_ready=1 -> real 8,16..96, imag=-8. out_sop on beat 1, out_eop on beat 12, latency 1, frame_cnt=1, no err.
- Same frame with out_ready toggling 1/0 every cycle -> in_ready deasserts when occupancy reaches 2. All 12 beats arrive in order and are held stable while stalled.
- Saturation (MRD_RX_SAT_EN defined): real=0x1FFFF, exp=15 -> out_real=0x7FFFFF. real=0x20000 -> 0x800000. With the macro undefined -> the low 24 bits of the shift.
- Early eop: dftpts=24 with in_eop on beat 10 -> out_eop on beat 10, one err_pulse, FSM back in IDLE. The next frame is handled normally.
- Missing eop: dftpts=12, frame runs for 15 beats -> out_eop on beat 12, err_pulse. Beats 13-15 are dropped, including eop beat 15. Next sop is accepted.
- sop at beat 5 of a 12-pt frame -> err_pulse, no out_eop. Beats dropped until in_eop. Assert rst_n mid-frame in a separate run -> all outputs at reset values next cycle.
